multi_cycle_ctrl: RTL and testbench
===================================

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 clk  input  1  single system clock; all state changes on rising edge.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 Op  input  6  opcode field of the instruction register.
REQ-004 Zero  input  1  ALU zero flag, sampled in BRANCH.
REQ-005 mem_ready  input  1  memory completion strobe; 1 = access finishes this cycle.
REQ-006 PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  output  1 each  datapath controls.
REQ-007 ALUSrcB  output  2  00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = immediate<<2.
REQ-008 PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-009 ALUop  output  2  to the ALU control stage: 00 = add, 01 = sub, 10 = R-type (Func), 11 = I-type (ImmFunc).
REQ-010 ImmFunc  output  6  func-equivalent for I-type: addi 100000, andi 100100, ori 100101, xori 100110, slti 101010; 000000 otherwise.
REQ-011 instr_done  output  1  one-cycle pulse on the last cycle of each instruction.
REQ-012 illegal_op  output  1  one-cycle pulse in DECODE for an unsupported opcode.

Function
REQ-013 Supported opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, addi 001000, andi 001100, ori 001101, xori 001110, slti 001010.
REQ-014 States (4-bit): FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EX, R_WB, BRANCH, JUMP, I_EX, I_WB; Moore outputs decoded from the state register, except for the mem_ready-gated enables.
REQ-015 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=00; IRWrite=PCWrite=mem_ready; stay while mem_ready=0, else go to DECODE.
REQ-016 DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=00; next state lw/sw -> MEM_ADDR, R -> R_EX, beq/bne -> BRANCH, j -> JUMP, I-ALU -> I_EX, other -> FETCH with illegal_op=1.
REQ-017 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUop=00; lw -> MEM_RD, sw -> MEM_WR.
REQ-018 MEM_RD: MemRead=1, IorD=1; hold until mem_ready=1, then go to MEM_WB. MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1, then FETCH.
REQ-019 MEM_WR: MemWrite=1, IorD=1; hold until mem_ready=1; instr_done=mem_ready; then FETCH.
REQ-020 R_EX: ALUSrcA=1, ALUSrcB=00, ALUop=10, then R_WB. R_WB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1.
REQ-021 I_EX: ALUSrcA=1, ALUSrcB=10, ALUop=11, then I_WB. I_WB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1.
REQ-022 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=01, BranchNe=(Op==000101), instr_done=1; the PC loads when Zero XOR BranchNe.
REQ-023 JUMP: PCWrite=1, PCSource=10, instr_done=1.
REQ-024 All unlisted outputs are 0 in every state; ImmFunc is combinational from Op.
REQ-025 Cycle counts with mem_ready=1 throughout: lw 5, sw 4, R 4, I 4, beq/bne 3, j 3, illegal 2.
REQ-026 Unreachable state encodings go to FETCH on the next edge.

Reset
REQ-027 rst_n=0 forces the state to FETCH immediately. While rst_n=0, PCWrite, IRWrite, MemWrite, RegWrite, PCWriteCond, instr_done and illegal_op are 0. All other outputs take their FETCH values.
REQ-028 Reset asserted mid-instruction abandons the instruction with no register or memory write; the first edge after rst_n deasserts begins FETCH.

Structure
REQ-029 Opcode constants, state encodings, ALUop codes and ImmFunc codes live in the shared cpu_defs header, which is also used by the ALU control stage.
REQ-030 One sub-module, ctrl_out_dec, decodes the state plus Op, Zero and mem_ready into the outputs; the top holds only the state register and next-state logic.

Verification
REQ-031 lw (Op=100011) with mem_ready=1 -> states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB; RegWrite=1 only in cycle 5; instr_done in cycle 5.
REQ-032 sw with mem_ready low for 3 cycles in MEM_WR -> MemWrite=1 for 4 cycles; MemWrite and instr_done fall together.
REQ-033 bne (000101) with Zero=0 -> BRANCH has PCWriteCond=1, BranchNe=1, PCSource=01. beq (000100) gives BranchNe=0.
REQ-034 ori (001101) -> I_EX has ALUop=11, ImmFunc=100101, ALUSrcB=10; I_WB has RegDst=0.
REQ-035 Op=111111 -> illegal_op pulse in DECODE, FETCH next, no write enables asserted.
REQ-036 rst_n dropped in R_EX for 1 cycle -> state becomes FETCH asynchronously, RegWrite never asserts, and the next instruction fetches normally.

Source files
------------

// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared CPU definitions: opcodes, controller states, ALUop and ImmFunc codes.
// The ALU control stage imports this package as well.
package multi_cycle_ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNC_W  = 6;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned SEL_W   = 2;

  localparam logic [OP_W-1:0] OP_R    = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE  = 6'b000101;
  localparam logic [OP_W-1:0] OP_J    = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [OP_W-1:0] OP_ANDI = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI  = 6'b001101;
  localparam logic [OP_W-1:0] OP_XORI = 6'b001110;
  localparam logic [OP_W-1:0] OP_SLTI = 6'b001010;

  localparam logic [FUNC_W-1:0] FN_ADD  = 6'b100000;
  localparam logic [FUNC_W-1:0] FN_AND  = 6'b100100;
  localparam logic [FUNC_W-1:0] FN_OR   = 6'b100101;
  localparam logic [FUNC_W-1:0] FN_XOR  = 6'b100110;
  localparam logic [FUNC_W-1:0] FN_SLT  = 6'b101010;
  localparam logic [FUNC_W-1:0] FN_NONE = 6'b000000;

  localparam logic [SEL_W-1:0] ALUOP_ADD = 2'b00;
  localparam logic [SEL_W-1:0] ALUOP_SUB = 2'b01;
  localparam logic [SEL_W-1:0] ALUOP_R   = 2'b10;
  localparam logic [SEL_W-1:0] ALUOP_I   = 2'b11;

  localparam logic [SEL_W-1:0] SRCB_B      = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM    = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EX     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EX     = 4'd10,
    S_I_WB     = 4'd11
  } state_e;

  typedef struct packed {
    logic              pc_write;
    logic              pc_write_cond;
    logic              branch_ne;
    logic              iord;
    logic              mem_read;
    logic              mem_write;
    logic              ir_write;
    logic              mem_to_reg;
    logic              reg_dst;
    logic              reg_write;
    logic              alu_src_a;
    logic [SEL_W-1:0]  alu_src_b;
    logic [SEL_W-1:0]  pc_source;
    logic [SEL_W-1:0]  alu_op;
    logic [FUNC_W-1:0] imm_func;
    logic              instr_done;
    logic              illegal_op;
  } ctrl_t;

  function automatic logic [FUNC_W-1:0] imm_func(input logic [OP_W-1:0] op);
    case (op)
      OP_ADDI: imm_func = FN_ADD;
      OP_ANDI: imm_func = FN_AND;
      OP_ORI:  imm_func = FN_OR;
      OP_XORI: imm_func = FN_XOR;
      OP_SLTI: imm_func = FN_SLT;
      default: imm_func = FN_NONE;
    endcase
  endfunction

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    case (op)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J,
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: is_legal_op = 1'b1;
      default:                                    is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction/status inputs and datapath controls.
interface multi_cycle_ctrl_if;
  import multi_cycle_ctrl_pkg::*;

  logic [OP_W-1:0]   Op;
  logic              Zero;
  logic              mem_ready;
  logic              PCWrite;
  logic              PCWriteCond;
  logic              BranchNe;
  logic              IorD;
  logic              MemRead;
  logic              MemWrite;
  logic              IRWrite;
  logic              MemtoReg;
  logic              RegDst;
  logic              RegWrite;
  logic              ALUSrcA;
  logic [SEL_W-1:0]  ALUSrcB;
  logic [SEL_W-1:0]  PCSource;
  logic [SEL_W-1:0]  ALUop;
  logic [FUNC_W-1:0] ImmFunc;
  logic              instr_done;
  logic              illegal_op;

  modport master (
    input  Op, Zero, mem_ready,
    output PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUop,
           ImmFunc, instr_done, illegal_op
  );

  modport slave (
    output Op, Zero, mem_ready,
    input  PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUop,
           ImmFunc, instr_done, illegal_op
  );

endinterface

// File: rtl/ctrl_out_dec.sv
// Output decoder: Moore controls from the state, plus the mem_ready-gated enables.
module ctrl_out_dec
  import multi_cycle_ctrl_pkg::*;
(
  input  logic            i_rst_n,
  input  state_e          i_state,
  input  logic [OP_W-1:0] i_op,
  input  logic            i_zero,
  input  logic            i_mem_ready,
  output ctrl_t           o_ctrl
);

  // Zero is combined with BranchNe in the datapath's PC-load logic.
  logic w_unused_zero;
  assign w_unused_zero = i_zero;

  always_comb begin
    o_ctrl          = '0;
    o_ctrl.imm_func = imm_func(i_op);
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b  = SRCB_IMM_SH;
        o_ctrl.illegal_op = ~is_legal_op(i_op);
      end
      S_MEM_ADDR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        o_ctrl.mem_write  = 1'b1;
        o_ctrl.iord       = 1'b1;
        o_ctrl.instr_done = i_mem_ready;
      end
      S_R_EX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_B;
        o_ctrl.alu_op    = ALUOP_R;
      end
      S_R_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_I_EX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_I;
      end
      S_I_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_B;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
        o_ctrl.branch_ne     = (i_op == OP_BNE);
        o_ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.pc_source  = PCSRC_JUMP;
        o_ctrl.instr_done = 1'b1;
      end
      default: ;
    endcase
    // Reset holds FETCH but must not let mem_ready leak into the write enables.
    if (!i_rst_n) begin
      o_ctrl.pc_write      = 1'b0;
      o_ctrl.ir_write      = 1'b0;
      o_ctrl.mem_write     = 1'b0;
      o_ctrl.reg_write     = 1'b0;
      o_ctrl.pc_write_cond = 1'b0;
      o_ctrl.instr_done    = 1'b0;
      o_ctrl.illegal_op    = 1'b0;
    end
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU main controller: state register and next-state logic.
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  multi_cycle_ctrl_if.master bus
);

  state_e r_state;
  state_e w_state_nxt;
  ctrl_t  w_ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = S_FETCH;
    case (r_state)
      S_FETCH:    w_state_nxt = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.Op)
          OP_LW, OP_SW:                               w_state_nxt = S_MEM_ADDR;
          OP_R:                                       w_state_nxt = S_R_EX;
          OP_BEQ, OP_BNE:                             w_state_nxt = S_BRANCH;
          OP_J:                                       w_state_nxt = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: w_state_nxt = S_I_EX;
          default:                                    w_state_nxt = S_FETCH;
        endcase
      end
      S_MEM_ADDR: w_state_nxt = (bus.Op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   w_state_nxt = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   w_state_nxt = bus.mem_ready ? S_FETCH : S_MEM_WR;
      S_R_EX:     w_state_nxt = S_R_WB;
      S_I_EX:     w_state_nxt = S_I_WB;
      default:    w_state_nxt = S_FETCH;
    endcase
  end

  ctrl_out_dec u_dec (
    .i_rst_n     (rst_n),
    .i_state     (r_state),
    .i_op        (bus.Op),
    .i_zero      (bus.Zero),
    .i_mem_ready (bus.mem_ready),
    .o_ctrl      (w_ctrl)
  );

  assign bus.PCWrite     = w_ctrl.pc_write;
  assign bus.PCWriteCond = w_ctrl.pc_write_cond;
  assign bus.BranchNe    = w_ctrl.branch_ne;
  assign bus.IorD        = w_ctrl.iord;
  assign bus.MemRead     = w_ctrl.mem_read;
  assign bus.MemWrite    = w_ctrl.mem_write;
  assign bus.IRWrite     = w_ctrl.ir_write;
  assign bus.MemtoReg    = w_ctrl.mem_to_reg;
  assign bus.RegDst      = w_ctrl.reg_dst;
  assign bus.RegWrite    = w_ctrl.reg_write;
  assign bus.ALUSrcA     = w_ctrl.alu_src_a;
  assign bus.ALUSrcB     = w_ctrl.alu_src_b;
  assign bus.PCSource    = w_ctrl.pc_source;
  assign bus.ALUop       = w_ctrl.alu_op;
  assign bus.ImmFunc     = w_ctrl.imm_func;
  assign bus.instr_done  = w_ctrl.instr_done;
  assign bus.illegal_op  = w_ctrl.illegal_op;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench: instruction-level model predicts every cycle's control vector.
module tb_multi_cycle_ctrl;

  typedef struct packed {
    logic       pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb, pcsrc, aluop;
    logic [5:0] immf;
    logic       done, ill;
  } out_t;

  typedef struct {
    out_t  exp;
    string tag;
  } sb_t;

  localparam int PH_RESET = 0, PH_FETCH = 1, PH_DECODE = 2, PH_ADDR = 3,
                 PH_RD = 4, PH_LWWB = 5, PH_WR = 6, PH_REX = 7, PH_RWB = 8,
                 PH_IEX = 9, PH_IWB = 10, PH_BR = 11, PH_J = 12;
  localparam int C_R = 0, C_LW = 1, C_SW = 2, C_BR = 3, C_J = 4, C_I = 5, C_ILL = 6;

  logic clk = 1'b0;
  logic rst_n;
  sb_t  sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   done_flag = 1'b0;
  logic [5:0] legal_ops [11] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                 6'b000101, 6'b000010, 6'b001000, 6'b001100,
                                 6'b001101, 6'b001110, 6'b001010};

  multi_cycle_ctrl_if bus ();

  multi_cycle_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic int op_class(input logic [5:0] op);
    case (op)
      6'b000000: return C_R;
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000100, 6'b000101: return C_BR;
      6'b000010: return C_J;
      6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010: return C_I;
      default: return C_ILL;
    endcase
  endfunction

  function automatic logic [5:0] exp_immf(input logic [5:0] op);
    case (op)
      6'b001000: return 6'b100000;
      6'b001100: return 6'b100100;
      6'b001101: return 6'b100101;
      6'b001110: return 6'b100110;
      6'b001010: return 6'b101010;
      default:   return 6'b000000;
    endcase
  endfunction

  // Expected controls for one cycle of a given instruction phase.
  function automatic out_t phase_out(input int ph, input logic [5:0] op, input logic mr);
    out_t o;
    o      = '0;
    o.immf = exp_immf(op);
    case (ph)
      PH_RESET:  begin o.mrd = 1; o.srcb = 2'b01; end
      PH_FETCH:  begin o.mrd = 1; o.srcb = 2'b01; o.irw = mr; o.pcw = mr; end
      PH_DECODE: begin o.srcb = 2'b11; o.ill = (op_class(op) == C_ILL); end
      PH_ADDR:   begin o.srca = 1; o.srcb = 2'b10; end
      PH_RD:     begin o.mrd = 1; o.iord = 1; end
      PH_LWWB:   begin o.rw = 1; o.m2r = 1; o.done = 1; end
      PH_WR:     begin o.mwr = 1; o.iord = 1; o.done = mr; end
      PH_REX:    begin o.srca = 1; o.aluop = 2'b10; end
      PH_RWB:    begin o.rw = 1; o.rdst = 1; o.done = 1; end
      PH_IEX:    begin o.srca = 1; o.srcb = 2'b10; o.aluop = 2'b11; end
      PH_IWB:    begin o.rw = 1; o.done = 1; end
      PH_BR:     begin o.srca = 1; o.aluop = 2'b01; o.pcwc = 1; o.pcsrc = 2'b01;
                       o.bne = (op == 6'b000101); o.done = 1; end
      PH_J:      begin o.pcw = 1; o.pcsrc = 2'b10; o.done = 1; end
      default: ;
    endcase
    return o;
  endfunction

  // Asynchronous reset check: FETCH values present, all write enables quiet.
  task automatic check_reset_state(input string tag);
    #1;
    if (bus.PCWrite || bus.IRWrite || bus.MemWrite || bus.RegWrite ||
        bus.PCWriteCond || bus.instr_done || bus.illegal_op ||
        (bus.MemRead !== 1'b1) || (bus.ALUSrcB !== 2'b01)) begin
      n_err++;
      $display("FAIL %s: reset state wrong pcw=%b irw=%b mwr=%b rw=%b mrd=%b srcb=%b",
               tag, bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite,
               bus.MemRead, bus.ALUSrcB);
    end
  endtask

  task automatic step(input logic r, input logic mr, input logic [5:0] op,
                      input int ph, input string tag);
    sb_t s;
    @(posedge clk);
    #1;
    rst_n         = r;
    bus.mem_ready = mr;
    bus.Op        = op;
    bus.Zero      = 1'($urandom);
    s.exp = phase_out(ph, op, mr);
    s.tag = tag;
    sb_q.push_back(s);
  endtask

  // One instruction: fw fetch stalls, mw memory stalls, optional reset in R_EX.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input bit abort);
    for (int i = 0; i < fw; i++) step(1, 0, op, PH_FETCH, "fetch_stall");
    step(1, 1, op, PH_FETCH, "fetch");
    step(1, 1'($urandom), op, PH_DECODE, "decode");
    case (op_class(op))
      C_LW: begin
        step(1, 1'($urandom), op, PH_ADDR, "lw_addr");
        for (int i = 0; i < mw; i++) step(1, 0, op, PH_RD, "lw_rd_stall");
        step(1, 1, op, PH_RD, "lw_rd");
        step(1, 1'($urandom), op, PH_LWWB, "lw_wb");
      end
      C_SW: begin
        step(1, 1'($urandom), op, PH_ADDR, "sw_addr");
        for (int i = 0; i < mw; i++) step(1, 0, op, PH_WR, "sw_wr_stall");
        step(1, 1, op, PH_WR, "sw_wr");
      end
      C_R: begin
        if (abort) begin
          step(0, 1'($urandom), op, PH_RESET, "r_abort_rst");
          check_reset_state("r_abort_async");
        end else begin
          step(1, 1'($urandom), op, PH_REX, "r_ex");
          step(1, 1'($urandom), op, PH_RWB, "r_wb");
        end
      end
      C_I: begin
        step(1, 1'($urandom), op, PH_IEX, "i_ex");
        step(1, 1'($urandom), op, PH_IWB, "i_wb");
      end
      C_BR: step(1, 1'($urandom), op, PH_BR, "branch");
      C_J:  step(1, 1'($urandom), op, PH_J, "jump");
      default: ;
    endcase
  endtask

  // Monitor: one expected vector per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_t  s;
      out_t act;
      s   = sb_q.pop_front();
      act = {bus.PCWrite, bus.PCWriteCond, bus.BranchNe, bus.IorD, bus.MemRead,
             bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite,
             bus.ALUSrcA, bus.ALUSrcB, bus.PCSource, bus.ALUop, bus.ImmFunc,
             bus.instr_done, bus.illegal_op};
      n_vec++;
      if (act !== s.exp) begin
        n_err++;
        $display("FAIL %s: op=%b got=%b exp=%b", s.tag, bus.Op, act, s.exp);
      end
    end
  end

  // Watchdog: the stimulus must complete within a bounded time.
  initial begin
    #2_000_000;
    if (!done_flag) begin
      $display("FAIL timeout: stimulus did not complete, %0d vectors applied", n_vec);
      $finish;
    end
  end

  initial begin
    logic [5:0] op;
    rst_n         = 1'b0;
    bus.Op        = '0;
    bus.Zero      = 1'b0;
    bus.mem_ready = 1'b0;
    step(0, 1, 6'b100011, PH_RESET, "reset");
    check_reset_state("reset_init");
    step(0, 0, 6'b001101, PH_RESET, "reset");

    run_instr(6'b100011, 0, 0, 0);   // lw
    run_instr(6'b101011, 0, 3, 0);   // sw, 3 stall cycles
    run_instr(6'b000101, 0, 0, 0);   // bne
    run_instr(6'b000100, 1, 0, 0);   // beq
    run_instr(6'b001101, 0, 0, 0);   // ori
    run_instr(6'b111111, 0, 0, 0);   // illegal
    run_instr(6'b000000, 0, 0, 1);   // R aborted by reset
    run_instr(6'b000000, 0, 0, 0);   // R after reset
    run_instr(6'b000010, 0, 0, 0);   // j

    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 4) == 0) op = 6'($urandom);
      else                           op = legal_ops[$urandom_range(0, 10)];
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), ($urandom_range(0, 9) == 0));
    end

    @(posedge clk);
    @(posedge clk);
    done_flag = 1'b1;
    if (sb_q.size() != 0 || n_err != 0)
      $display("FAIL: %0d miscompares, %0d vectors left unchecked", n_err, sb_q.size());
    else
      $display("PASS");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
